// File: rtl/scan_cmd_pkg.sv
// Shared constants and types for the scan-chain command sequencer.
package scan_cmd_pkg;

   // Command opcodes received from the host
   localparam logic [7:0] OP_SEL   = 8'h53;  // 'S' select project index
   localparam logic [7:0] OP_MODE  = 8'h4D;  // 'M' scan mode select
   localparam logic [7:0] OP_WRITE = 8'h57;  // 'W' write inputs, wait for READY

   // Response bytes returned to the host
   localparam logic [7:0] RSP_OK      = 8'h4B;  // 'K'
   localparam logic [7:0] RSP_TIMEOUT = 8'h54;  // 'T'
   localparam logic [7:0] RSP_ERR     = 8'h3F;  // '?'

   // Mode driven while idle after reset
   localparam logic [1:0] MODE_RESET = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ARG1     = 3'd1,
      ST_ARG2     = 3'd2,
      ST_WAIT_RDY = 3'd3,
      ST_RESP0    = 3'd4,
      ST_RESP1    = 3'd5
   } state_e;

   // True for opcodes that take arguments
   function automatic logic is_opcode(input logic [7:0] b);
      return (b == OP_SEL) || (b == OP_MODE) || (b == OP_WRITE);
   endfunction

endpackage

// File: rtl/scan_cmd_sequencer_sync_rise.sv
// Two-flop synchronizer with a registered rising-edge pulse. Edge detection
// only looks for a low-to-high transition seen while arm is high; while
// disarmed the previous level is treated as high so a level that is already
// high at arming time never produces a pulse.
module sync_rise (
   input  logic clk,
   input  logic rst_n,
   input  logic arm,
   input  logic din,
   output logic rise
);

   logic s1_r;
   logic s2_r;
   logic prev_r;
   logic rise_r;

   // Synchronize the async input and detect an armed rising edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_r   <= 1'b0;
         s2_r   <= 1'b0;
         prev_r <= 1'b0;
         rise_r <= 1'b0;
      end else begin
         s1_r   <= din;
         s2_r   <= s1_r;
         prev_r <= arm ? s2_r : 1'b1;
         rise_r <= arm & s2_r & ~prev_r;
      end
   end

   assign rise = rise_r;

endmodule

// File: rtl/scan_cmd_sequencer.sv
// Byte-command sequencer between the UART and the scan-chain harness.
// Parses S/M/W frames, drives index/mode/inputs, waits for harness READY
// and returns response bytes with a valid/ready handshake.
module scan_cmd_sequencer
   import scan_cmd_pkg::*;
#(
   parameter int IDX_W         = 9,
   parameter int RDY_TIMEOUT   = 1000000,
   parameter int FRAME_TIMEOUT = 100000
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic [IDX_W-1:0] proj_index,
   output logic [1:0]       mode,
   output logic [7:0]       proj_inputs,
   input  logic [7:0]       proj_outputs,
   input  logic             proj_ready,
   output logic             busy,
   output logic             rx_overrun
);

   localparam int RDY_W = $clog2(RDY_TIMEOUT + 1);
   localparam int FRM_W = $clog2(FRAME_TIMEOUT + 1);
   localparam logic [RDY_W-1:0] RDY_LAST = RDY_W'(RDY_TIMEOUT - 1);
   localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAME_TIMEOUT - 1);
   localparam logic [RDY_W-1:0] RDY_ONE  = RDY_W'(1);
   localparam logic [FRM_W-1:0] FRM_ONE  = FRM_W'(1);

   state_e           state_r, state_s;
   logic [7:0]       op_r, op_s;
   logic [7:0]       hi_r, hi_s;
   logic [7:0]       data_r, data_s;
   logic [RDY_W-1:0] rdy_cnt_r, rdy_cnt_s;
   logic [FRM_W-1:0] frm_cnt_r, frm_cnt_s;
   logic [IDX_W-1:0] proj_index_r, proj_index_s;
   logic [1:0]       mode_r, mode_s;
   logic [7:0]       proj_inputs_r, proj_inputs_s;
   logic [7:0]       tx_data_r, tx_data_s;
   logic             tx_valid_r, tx_valid_s;
   logic             busy_r;
   logic             rx_overrun_r, rx_overrun_s;
   logic             rdy_rise_s;

   sync_rise u_sync_rise (
      .clk   (CLK),
      .rst_n (RESET_N),
      .arm   (state_r == ST_WAIT_RDY),
      .din   (proj_ready),
      .rise  (rdy_rise_s)
   );

   // Next-state and next-output decode for the command FSM
   always_comb begin
      state_s       = state_r;
      op_s          = op_r;
      hi_s          = hi_r;
      data_s        = data_r;
      rdy_cnt_s     = rdy_cnt_r;
      frm_cnt_s     = frm_cnt_r;
      proj_index_s  = proj_index_r;
      mode_s        = mode_r;
      proj_inputs_s = proj_inputs_r;
      tx_data_s     = tx_data_r;
      tx_valid_s    = tx_valid_r;
      rx_overrun_s  = 1'b0;

      case (state_r)
         ST_IDLE: begin
            frm_cnt_s = {FRM_W{1'b0}};
            if (rx_valid) begin
               op_s = rx_data;
               if (is_opcode(rx_data)) begin
                  state_s = ST_ARG1;
               end else begin
                  state_s    = ST_RESP0;
                  tx_data_s  = RSP_ERR;
                  tx_valid_s = 1'b1;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_ARG1: begin
            if (rx_valid) begin
               frm_cnt_s = {FRM_W{1'b0}};
               case (op_r)
                  OP_SEL: begin
                     hi_s    = rx_data;
                     state_s = ST_ARG2;
                  end
                  OP_MODE: begin
                     mode_s     = rx_data[1:0];
                     tx_data_s  = RSP_OK;
                     tx_valid_s = 1'b1;
                     state_s    = ST_RESP0;
                  end
                  OP_WRITE: begin
                     proj_inputs_s = rx_data;
                     rdy_cnt_s     = {RDY_W{1'b0}};
                     state_s       = ST_WAIT_RDY;
                  end
                  default: begin
                     state_s = ST_IDLE;
                  end
               endcase
            end else if (frm_cnt_r == FRM_LAST) begin
               state_s = ST_IDLE;
            end else begin
               frm_cnt_s = frm_cnt_r + FRM_ONE;
            end
         end

         ST_ARG2: begin
            if (rx_valid) begin
               frm_cnt_s    = {FRM_W{1'b0}};
               proj_index_s = IDX_W'({hi_r, rx_data});
               tx_data_s    = RSP_OK;
               tx_valid_s   = 1'b1;
               state_s      = ST_RESP0;
            end else if (frm_cnt_r == FRM_LAST) begin
               state_s = ST_IDLE;
            end else begin
               frm_cnt_s = frm_cnt_r + FRM_ONE;
            end
         end

         ST_WAIT_RDY: begin
            rx_overrun_s = rx_valid;
            // An edge seen in the final timeout cycle still counts as success
            if (rdy_rise_s) begin
               tx_data_s  = RSP_OK;
               data_s     = proj_outputs;
               tx_valid_s = 1'b1;
               state_s    = ST_RESP0;
            end else if (rdy_cnt_r == RDY_LAST) begin
               tx_data_s  = RSP_TIMEOUT;
               data_s     = 8'h00;
               tx_valid_s = 1'b1;
               state_s    = ST_RESP0;
            end else begin
               rdy_cnt_s = rdy_cnt_r + RDY_ONE;
            end
         end

         ST_RESP0: begin
            rx_overrun_s = rx_valid;
            if (tx_valid_r && tx_ready) begin
               if (op_r == OP_WRITE) begin
                  tx_data_s = data_r;
                  state_s   = ST_RESP1;
               end else begin
                  tx_valid_s = 1'b0;
                  state_s    = ST_IDLE;
               end
            end else begin
               state_s = ST_RESP0;
            end
         end

         ST_RESP1: begin
            rx_overrun_s = rx_valid;
            if (tx_valid_r && tx_ready) begin
               tx_valid_s = 1'b0;
               state_s    = ST_IDLE;
            end else begin
               state_s = ST_RESP1;
            end
         end

         default: begin
            tx_valid_s = 1'b0;
            state_s    = ST_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_r       <= ST_IDLE;
         op_r          <= 8'h00;
         hi_r          <= 8'h00;
         data_r        <= 8'h00;
         rdy_cnt_r     <= {RDY_W{1'b0}};
         frm_cnt_r     <= {FRM_W{1'b0}};
         proj_index_r  <= {IDX_W{1'b0}};
         mode_r        <= MODE_RESET;
         proj_inputs_r <= 8'h00;
         tx_data_r     <= 8'h00;
         tx_valid_r    <= 1'b0;
         busy_r        <= 1'b0;
         rx_overrun_r  <= 1'b0;
      end else begin
         state_r       <= state_s;
         op_r          <= op_s;
         hi_r          <= hi_s;
         data_r        <= data_s;
         rdy_cnt_r     <= rdy_cnt_s;
         frm_cnt_r     <= frm_cnt_s;
         proj_index_r  <= proj_index_s;
         mode_r        <= mode_s;
         proj_inputs_r <= proj_inputs_s;
         tx_data_r     <= tx_data_s;
         tx_valid_r    <= tx_valid_s;
         busy_r        <= (state_s != ST_IDLE);
         rx_overrun_r  <= rx_overrun_s;
      end
   end

   assign tx_data     = tx_data_r;
   assign tx_valid    = tx_valid_r;
   assign proj_index  = proj_index_r;
   assign mode        = mode_r;
   assign proj_inputs = proj_inputs_r;
   assign busy        = busy_r;
   assign rx_overrun  = rx_overrun_r;

endmodule

// File: tb/tb_scan_cmd_sequencer.sv
// Directed bench for scan_cmd_sequencer. A frame-level model predicts the
// harness-facing outputs, the expected response byte stream and overrun
// pulses; a per-cycle compare routine checks the DUT against it.
module tb_scan_cmd_sequencer;

   localparam int IDX_W = 9;
   localparam int RT    = 50;
   localparam int FT    = 30;

   logic             CLK;
   logic             RESET_N;
   logic [7:0]       rx_data;
   logic             rx_valid;
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic [IDX_W-1:0] proj_index;
   logic [1:0]       mode;
   logic [7:0]       proj_inputs;
   logic [7:0]       proj_outputs;
   logic             proj_ready;
   logic             busy;
   logic             rx_overrun;

   scan_cmd_sequencer #(.IDX_W(IDX_W), .RDY_TIMEOUT(RT), .FRAME_TIMEOUT(FT)) dut (
      .CLK          (CLK),
      .RESET_N      (RESET_N),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .proj_index   (proj_index),
      .mode         (mode),
      .proj_inputs  (proj_inputs),
      .proj_outputs (proj_outputs),
      .proj_ready   (proj_ready),
      .busy         (busy),
      .rx_overrun   (rx_overrun)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // model state
   logic [8:0] exp_idx;
   logic [1:0] exp_mode;
   logic [7:0] exp_pin;
   logic       exp_ovr;
   logic [7:0] w_stat;
   logic [7:0] w_data;
   logic [7:0] exp_q[$];
   logic [7:0] fq[$];
   logic [7:0] tx_hist[$];
   int         cyc;
   int         last_cyc;
   int         checks;
   int         errors;
   bit         prev_hold;
   logic [7:0] prev_data;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, want, $time);
      end
   endtask

   task automatic model_reset();
      exp_idx   = 9'h000;
      exp_mode  = 2'b10;
      exp_pin   = 8'h00;
      exp_ovr   = 1'b0;
      prev_hold = 1'b0;
      exp_q.delete();
      fq.delete();
   endtask

   // frame-level interpretation of an accepted byte
   task automatic model_byte(input logic [7:0] b);
      if (fq.size() != 0 && (cyc - last_cyc - 1) >= FT) fq.delete();
      last_cyc = cyc;
      if (fq.size() == 0) begin
         if (b == 8'h53 || b == 8'h4D || b == 8'h57) fq.push_back(b);
         else exp_q.push_back(8'h3F);
      end else begin
         fq.push_back(b);
         if (fq[0] == 8'h53) begin
            if (fq.size() == 3) begin
               exp_idx = {fq[1][0], fq[2]};
               exp_q.push_back(8'h4B);
               fq.delete();
            end
         end else if (fq[0] == 8'h4D) begin
            exp_mode = b[1:0];
            exp_q.push_back(8'h4B);
            fq.delete();
         end else begin
            exp_pin = b;
            exp_q.push_back(w_stat);
            exp_q.push_back(w_data);
            fq.delete();
         end
      end
   endtask

   task automatic compare_cycle();
      logic [7:0] want;
      chk("proj_index", 32'(proj_index), 32'(exp_idx));
      chk("mode", 32'(mode), 32'(exp_mode));
      chk("proj_inputs", 32'(proj_inputs), 32'(exp_pin));
      chk("rx_overrun", 32'(rx_overrun), 32'(exp_ovr));
      if (prev_hold) begin
         chk("tx_hold_valid", 32'(tx_valid), 32'd1);
         chk("tx_hold_data", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid && tx_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_tx", 32'(tx_data), 32'hFFFF_FFFF);
         end else begin
            want = exp_q.pop_front();
            chk("tx_byte", 32'(tx_data), 32'(want));
         end
         tx_hist.push_back(tx_data);
      end
      prev_hold = tx_valid && !tx_ready;
      prev_data = tx_data;
   endtask

   task automatic step();
      @(negedge CLK);
      compare_cycle();
      @(posedge CLK);
      #1;
      cyc++;
      exp_ovr = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit drop;
      drop = (exp_q.size() != 0);
      rx_data  = b;
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
      if (drop) exp_ovr = 1'b1;
      else model_byte(b);
   endtask

   task automatic wait_empty(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         step();
         n++;
      end
      if (exp_q.size() != 0) begin
         chk("resp_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
      step();
   endtask

   task automatic wait_tx_valid(output int n);
      n = 0;
      while (!tx_valid && n < 200) begin
         step();
         n++;
      end
   endtask

   task automatic ready_pulse(input int delay);
      repeat (delay) step();
      proj_ready = 1'b1;
      repeat (4) step();
      proj_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      int hsz;
      checks = 0; errors = 0; cyc = 0; last_cyc = 0;
      RESET_N = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
      proj_outputs = 8'h00; proj_ready = 1'b0;
      w_stat = 8'h4B; w_data = 8'h00;
      model_reset();
      repeat (3) step();
      RESET_N = 1'b1;
      step();
      chk("rst_proj_index", 32'(proj_index), 32'h0);
      chk("rst_mode", 32'(mode), 32'h2);
      chk("rst_proj_inputs", 32'(proj_inputs), 32'h0);
      chk("rst_tx_valid", 32'(tx_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);

      // select project 0x12A
      send_byte(8'h53); send_byte(8'h01); send_byte(8'h2A);
      chk("sel_index", 32'(proj_index), 32'h12A);
      chk("sel_tx_valid", 32'(tx_valid), 32'h1);
      chk("sel_tx_data", 32'(tx_data), 32'h4B);
      chk("sel_busy", 32'(busy), 32'h1);
      wait_empty(20);
      chk("sel_busy_low", 32'(busy), 32'h0);
      chk("sel_hist", 32'(tx_hist[tx_hist.size()-1]), 32'h4B);

      // mode 3
      send_byte(8'h4D); send_byte(8'h03);
      wait_empty(20);
      chk("mode_val", 32'(mode), 32'h3);

      // write with READY pulse 20 cycles later
      w_stat = 8'h4B; w_data = 8'h3C; proj_outputs = 8'h3C;
      send_byte(8'h57); send_byte(8'hA5);
      chk("wr_inputs", 32'(proj_inputs), 32'hA5);
      ready_pulse(20);
      wait_empty(60);
      chk("wr_hist0", 32'(tx_hist[tx_hist.size()-2]), 32'h4B);
      chk("wr_hist1", 32'(tx_hist[tx_hist.size()-1]), 32'h3C);

      // READY already high before the command must not capture
      proj_ready = 1'b1; proj_outputs = 8'h11;
      repeat (5) step();
      w_stat = 8'h54; w_data = 8'h00;
      send_byte(8'h57); send_byte(8'h5A);
      wait_tx_valid(n);
      chk("hi_lat", 32'(n), 32'd50);
      wait_empty(20);
      chk("hi_hist0", 32'(tx_hist[tx_hist.size()-2]), 32'h54);
      chk("hi_hist1", 32'(tx_hist[tx_hist.size()-1]), 32'h00);
      proj_ready = 1'b0;
      repeat (4) step();

      // plain timeout
      send_byte(8'h57); send_byte(8'h01);
      wait_tx_valid(n);
      chk("to_lat", 32'(n), 32'd50);
      chk("to_status", 32'(tx_data), 32'h54);
      wait_empty(20);

      // unknown opcode
      send_byte(8'h00);
      chk("err_tx", 32'(tx_data), 32'h3F);
      wait_empty(20);

      // frame timeout: partial select is abandoned silently
      send_byte(8'h53);
      chk("frm_busy", 32'(busy), 32'h1);
      repeat (FT + 5) step();
      chk("frm_idle", 32'(busy), 32'h0);
      chk("frm_index", 32'(proj_index), 32'h12A);
      send_byte(8'h00);
      wait_empty(20);
      chk("frm_hist", 32'(tx_hist[tx_hist.size()-1]), 32'h3F);

      // backpressure
      tx_ready = 1'b0;
      send_byte(8'h4D); send_byte(8'h01);
      repeat (10) step();
      chk("bp_valid", 32'(tx_valid), 32'h1);
      chk("bp_data", 32'(tx_data), 32'h4B);
      tx_ready = 1'b1;
      wait_empty(20);
      chk("bp_mode", 32'(mode), 32'h1);

      // overrun during wait
      w_stat = 8'h4B; w_data = 8'hC3; proj_outputs = 8'hC3;
      send_byte(8'h57); send_byte(8'h66);
      repeat (5) step();
      send_byte(8'h53);
      chk("ovr_pulse", 32'(rx_overrun), 32'h1);
      ready_pulse(5);
      wait_empty(60);
      chk("ovr_hist0", 32'(tx_hist[tx_hist.size()-2]), 32'h4B);
      chk("ovr_hist1", 32'(tx_hist[tx_hist.size()-1]), 32'hC3);

      // reset during wait
      send_byte(8'h57); send_byte(8'h77);
      repeat (5) step();
      hsz = tx_hist.size();
      #2 RESET_N = 1'b0;
      #1;
      model_reset();
      chk("mrst_inputs", 32'(proj_inputs), 32'h0);
      chk("mrst_index", 32'(proj_index), 32'h0);
      chk("mrst_mode", 32'(mode), 32'h2);
      chk("mrst_busy", 32'(busy), 32'h0);
      chk("mrst_tx_valid", 32'(tx_valid), 32'h0);
      repeat (2) step();
      RESET_N = 1'b1;
      repeat (60) step();
      chk("mrst_no_tx", 32'(tx_hist.size()), 32'(hsz));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
